// File: rtl/clock_pkg.sv
// Shared types, BCD limits and digit helpers for the time-of-day counter.
package clock_pkg;

  typedef enum logic [0:0] {
    ST_RUN,
    ST_CHECK
  } state_t;

  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HOUR_MAX = 8'h23;

  // With both nibbles <= 9 a packed-BCD compare orders like a decimal compare.
  function automatic logic bcd_valid(input logic [7:0] value, input logic [7:0] max);
    return (value[3:0] <= 4'd9) && (value[7:4] <= 4'd9) && (value <= max);
  endfunction

  function automatic logic [7:0] bcd_next(input logic [7:0] value, input logic [7:0] max);
    logic [7:0] result;
    result = value;
    if (value == max) begin
      result = 8'h00;
    end else if (value[3:0] == 4'd9) begin
      result = {value[7:4] + 4'd1, 4'd0};
    end else begin
      result = {value[7:4], value[3:0] + 4'd1};
    end
    return result;
  endfunction

endpackage

// File: rtl/time_of_day_counter_if.sv
// Valid/ready load port used to set the time; the slave side is the counter.
interface time_of_day_counter_if;

  logic       LOAD_VALID;
  logic       LOAD_READY;
  logic [7:0] LOAD_HH;
  logic [7:0] LOAD_MM;
  logic [7:0] LOAD_SS;
  logic       LOAD_ACK;
  logic       LOAD_ERR;

  modport master (
    output LOAD_VALID, LOAD_HH, LOAD_MM, LOAD_SS,
    input  LOAD_READY, LOAD_ACK, LOAD_ERR
  );

  modport slave (
    input  LOAD_VALID, LOAD_HH, LOAD_MM, LOAD_SS,
    output LOAD_READY, LOAD_ACK, LOAD_ERR
  );

endinterface

// File: rtl/bcd_mod_counter.sv
// Two-digit packed-BCD counter wrapping at MAX, with a same-edge carry out.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter logic [7:0] MAX = 8'h59
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] value,
  output logic       carry
);

  logic [7:0] r_value;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_value <= 8'h00;
    end else if (load) begin
      r_value <= load_val;
    end else if (inc) begin
      r_value <= bcd_next(r_value, MAX);
    end
  end

  // Carry is combinational so the next digit pair advances on the same edge.
  assign value = r_value;
  assign carry = inc && (r_value == MAX);

endmodule

// File: rtl/time_of_day_counter.sv
// 24-hour BCD time-of-day counter with a one-second prescaler and a
// validated two-step load path (accept, then check-and-apply).
module time_of_day_counter
  import clock_pkg::*;
#(
  parameter  int TICKS_PER_SEC = 10,
  localparam int PRESC_W       = $clog2(TICKS_PER_SEC)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 EN,
  time_of_day_counter_if.slave load_if,
  output logic [7:0]           HH,
  output logic [7:0]           MM,
  output logic [7:0]           SS,
  output logic                 SEC_PULSE,
  output logic                 ROLLOVER
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);

  state_t             r_state;
  state_t             w_next;
  logic [PRESC_W-1:0] r_presc;
  logic [7:0]         r_hold_hh;
  logic [7:0]         r_hold_mm;
  logic [7:0]         r_hold_ss;
  logic               r_sec_pulse;
  logic               r_rollover;
  logic               r_ack;
  logic               r_err;

  logic               w_accept;
  logic               w_apply;
  logic               w_reject;
  logic               w_advance;
  logic               w_tick;
  logic               w_hold_ok;
  logic               w_ss_carry;
  logic               w_mm_carry;
  logic               w_hh_carry;

  assign w_hold_ok = bcd_valid(r_hold_hh, HOUR_MAX) &&
                     bcd_valid(r_hold_mm, MIN_MAX)  &&
                     bcd_valid(r_hold_ss, SEC_MAX);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next;
    end
  end

  // An accepted load freezes time on its edge, so a tick due then is dropped.
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_apply   = 1'b0;
    w_reject  = 1'b0;
    w_advance = 1'b0;
    w_tick    = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (load_if.LOAD_VALID) begin
          w_accept = 1'b1;
          w_next   = ST_CHECK;
        end else if (EN) begin
          w_advance = 1'b1;
          w_tick    = (r_presc == PRESC_LAST);
        end
      end
      ST_CHECK: begin
        w_next = ST_RUN;
        if (w_hold_ok) begin
          w_apply = 1'b1;
        end else begin
          w_reject = 1'b1;
        end
      end
      default: begin
        w_next = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_presc <= '0;
    end else if (w_apply || w_tick) begin
      r_presc <= '0;
    end else if (w_advance) begin
      r_presc <= r_presc + PRESC_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_hold_hh <= 8'h00;
      r_hold_mm <= 8'h00;
      r_hold_ss <= 8'h00;
    end else if (w_accept) begin
      r_hold_hh <= load_if.LOAD_HH;
      r_hold_mm <= load_if.LOAD_MM;
      r_hold_ss <= load_if.LOAD_SS;
    end
  end

  bcd_mod_counter #(.MAX(SEC_MAX)) u_ss (
    .CLK      (CLK),
    .RST      (RST),
    .inc      (w_tick),
    .load     (w_apply),
    .load_val (r_hold_ss),
    .value    (SS),
    .carry    (w_ss_carry)
  );

  bcd_mod_counter #(.MAX(MIN_MAX)) u_mm (
    .CLK      (CLK),
    .RST      (RST),
    .inc      (w_ss_carry),
    .load     (w_apply),
    .load_val (r_hold_mm),
    .value    (MM),
    .carry    (w_mm_carry)
  );

  bcd_mod_counter #(.MAX(HOUR_MAX)) u_hh (
    .CLK      (CLK),
    .RST      (RST),
    .inc      (w_mm_carry),
    .load     (w_apply),
    .load_val (r_hold_hh),
    .value    (HH),
    .carry    (w_hh_carry)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sec_pulse <= 1'b0;
      r_rollover  <= 1'b0;
      r_ack       <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_sec_pulse <= w_tick;
      r_rollover  <= w_hh_carry;
      r_ack       <= w_apply;
      r_err       <= w_reject;
    end
  end

  assign SEC_PULSE          = r_sec_pulse;
  assign ROLLOVER           = r_rollover;
  assign load_if.LOAD_ACK   = r_ack;
  assign load_if.LOAD_ERR   = r_err;
  assign load_if.LOAD_READY = (r_state == ST_RUN);

endmodule

// File: tb/tb_time_of_day_counter.sv
// Directed bench for time_of_day_counter with TICKS_PER_SEC = 4.
module tb_time_of_day_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [7:0] hhOut;
  logic [7:0] mmOut;
  logic [7:0] ssOut;
  logic       secPulse;
  logic       rollover;
  int         checkCount = 0;
  int         passCount  = 0;
  int         pulseSeen  = 0;

  time_of_day_counter_if loadBus ();

  time_of_day_counter #(.TICKS_PER_SEC(4)) dut (
    .CLK       (clk),
    .RST       (rst),
    .EN        (en),
    .load_if   (loadBus),
    .HH        (hhOut),
    .MM        (mmOut),
    .SS        (ssOut),
    .SEC_PULSE (secPulse),
    .ROLLOVER  (rollover)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkTime(input string tag, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    checkOutput({tag, "-hh"}, hhOut, h);
    checkOutput({tag, "-mm"}, mmOut, m);
    checkOutput({tag, "-ss"}, ssOut, s);
  endtask

  // Presents one load for exactly one accept edge, then drops LOAD_VALID.
  task automatic applyStimulus(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    loadBus.LOAD_VALID = 1'b1;
    loadBus.LOAD_HH    = h;
    loadBus.LOAD_MM    = m;
    loadBus.LOAD_SS    = s;
    step(1);
    loadBus.LOAD_VALID = 1'b0;
  endtask

  task automatic loadAndCheck(input string tag, input logic [7:0] h, input logic [7:0] m,
                              input logic [7:0] s, input logic expAck);
    applyStimulus(h, m, s);
    checkOutput({tag, "-readyLow"}, 8'(loadBus.LOAD_READY), 8'd0);
    step(1);
    checkOutput({tag, "-readyHigh"}, 8'(loadBus.LOAD_READY), 8'd1);
    checkOutput({tag, "-ack"}, 8'(loadBus.LOAD_ACK), 8'(expAck));
    checkOutput({tag, "-err"}, 8'(loadBus.LOAD_ERR), 8'(!expAck));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    loadBus.LOAD_VALID = 1'b0;
    loadBus.LOAD_HH    = 8'h00;
    loadBus.LOAD_MM    = 8'h00;
    loadBus.LOAD_SS    = 8'h00;

    // Reset, then free-run twelve edges.
    rst = 1'b1;
    step(2);
    checkTime("reset", 8'h00, 8'h00, 8'h00);
    checkOutput("reset-ready", 8'(loadBus.LOAD_READY), 8'd1);
    checkOutput("reset-pulse", 8'(secPulse), 8'd0);
    checkOutput("reset-rollover", 8'(rollover), 8'd0);
    checkOutput("reset-ack", 8'(loadBus.LOAD_ACK), 8'd0);
    checkOutput("reset-err", 8'(loadBus.LOAD_ERR), 8'd0);
    rst = 1'b0;
    en  = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      checkOutput($sformatf("t1-pulse%0d", k), 8'(secPulse), 8'(k % 4 == 0));
    end
    checkTime("t1", 8'h00, 8'h00, 8'h03);

    // Valid load of 23:59:58, then run through midnight.
    loadAndCheck("t2-load", 8'h23, 8'h59, 8'h58, 1'b1);
    checkTime("t2-loaded", 8'h23, 8'h59, 8'h58);
    step(1);
    checkOutput("t2-ackOneCycle", 8'(loadBus.LOAD_ACK), 8'd0);
    step(3);
    checkTime("t2-59", 8'h23, 8'h59, 8'h59);
    checkOutput("t2-pulse59", 8'(secPulse), 8'd1);
    checkOutput("t2-noRoll59", 8'(rollover), 8'd0);
    step(3);
    checkOutput("t2-pulseGap", 8'(secPulse), 8'd0);
    step(1);
    checkTime("t2-midnight", 8'h00, 8'h00, 8'h00);
    checkOutput("t2-rollover", 8'(rollover), 8'd1);
    checkOutput("t2-pulseMid", 8'(secPulse), 8'd1);

    // Invalid loads are rejected and leave the time alone.
    en = 1'b0;
    loadAndCheck("t3-hh24", 8'h24, 8'h00, 8'h00, 1'b0);
    checkTime("t3-hh24", 8'h00, 8'h00, 8'h00);
    loadAndCheck("t3-ss5A", 8'h00, 8'h00, 8'h5A, 1'b0);
    checkTime("t3-ss5A", 8'h00, 8'h00, 8'h00);
    loadAndCheck("t3-mm60", 8'h00, 8'h60, 8'h00, 1'b0);
    checkTime("t3-mm60", 8'h00, 8'h00, 8'h00);

    // Load accepted on the edge a tick is due: the tick is dropped.
    loadAndCheck("t4-pre", 8'h00, 8'h00, 8'h05, 1'b1);
    en = 1'b1;
    step(3);
    applyStimulus(8'h10, 8'h20, 8'h30);
    checkOutput("t4-dropSS", ssOut, 8'h05);
    checkOutput("t4-dropPulse", 8'(secPulse), 8'd0);
    step(1);
    checkTime("t4-applied", 8'h10, 8'h20, 8'h30);
    checkOutput("t4-ack", 8'(loadBus.LOAD_ACK), 8'd1);
    step(3);
    checkOutput("t4-noEarlyPulse", 8'(secPulse), 8'd0);
    step(1);
    checkOutput("t4-pulse", 8'(secPulse), 8'd1);
    checkOutput("t4-ss", ssOut, 8'h31);

    // Disabled counting holds time; loads still work.
    en = 1'b0;
    loadAndCheck("t5-pre", 8'h12, 8'h34, 8'h56, 1'b1);
    for (int k = 0; k < 20; k++) begin
      step(1);
      if (secPulse || rollover) pulseSeen++;
    end
    checkOutput("t5-noPulses", 8'(pulseSeen), 8'd0);
    checkTime("t5-held", 8'h12, 8'h34, 8'h56);
    loadAndCheck("t5-load", 8'h01, 8'h02, 8'h03, 1'b1);
    checkTime("t5-loaded", 8'h01, 8'h02, 8'h03);

    // Reset during the check cycle discards the pending load.
    applyStimulus(8'h05, 8'h06, 8'h07);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checkTime("t6", 8'h00, 8'h00, 8'h00);
    checkOutput("t6-ack", 8'(loadBus.LOAD_ACK), 8'd0);
    checkOutput("t6-ready", 8'(loadBus.LOAD_READY), 8'd1);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/time_of_day_counter.md
Name: time_of_day_counter

Overview:
Consumes the free-running CLK from the clock generator and produces a 24-hour time-of-day in packed BCD (HH:MM:SS). An internal prescaler derives a one-second tick from CLK. A valid/ready load port lets a front panel or testbench set the time; illegal BCD values are rejected. Downstream display and alarm logic read HH/MM/SS and the pulse outputs.

Parameters:
TICKS_PER_SEC, 10, CLK cycles per second tick; must be >= 2. Simulation uses 4.
PRESC_W, $clog2(TICKS_PER_SEC), prescaler width; derived, not overridden.

Ports:
CLK  input  1  system clock from the clock generator; all logic on the rising edge.
RST  input  1  synchronous, active-high reset.
EN  input  1  count enable; 0 freezes the prescaler and time.
LOAD_VALID  input  1  load request; LOAD_HH/MM/SS are stable while high.
LOAD_READY  output  1  block can accept a load.
LOAD_HH  input  8  BCD hours to load, {tens[7:4], units[3:0]}.
LOAD_MM  input  8  BCD minutes to load.
LOAD_SS  input  8  BCD seconds to load.
LOAD_ACK  output  1  one-cycle pulse: the load was applied.
LOAD_ERR  output  1  one-cycle pulse: the load was rejected as invalid.
HH  output  8  current hours in BCD, 00-23.
MM  output  8  current minutes in BCD, 00-59.
SS  output  8  current seconds in BCD, 00-59.
SEC_PULSE  output  1  one-cycle pulse on the edge where SS increments.
ROLLOVER  output  1  one-cycle pulse on the 23:59:59 -> 00:00:00 edge.

Behaviour:
- Reset (sync, RST=1 at a rising edge):
  - HH/MM/SS = 00; prescaler = 0; FSM = ST_RUN; LOAD_READY = 1 from the next cycle.
  - SEC_PULSE, ROLLOVER, LOAD_ACK, LOAD_ERR = 0.
  - RST overrides everything, including a load in progress, which is discarded.
- Prescaler:
  - In ST_RUN with EN=1, counts 0..TICKS_PER_SEC-1.
  - On the edge where it wraps from TICKS_PER_SEC-1 to 0, the time increments and SEC_PULSE is registered high for exactly one cycle.
  - First SEC_PULSE after reset is high in the cycle following edge TICKS_PER_SEC.
- BCD increment, with a carry chain on the same edge:
  - SS units 9 -> 0 carries into SS tens; SS 59 -> 00 carries into MM.
  - MM 59 -> 00 carries into HH; HH 23 -> 00 asserts ROLLOVER (registered, one cycle, coincident with SEC_PULSE).
  - Digits never leave their legal range.
- FSM states: ST_RUN, ST_CHECK.
  - ST_RUN: LOAD_READY = 1. On LOAD_VALID & LOAD_READY, capture LOAD_* into holding registers and go to ST_CHECK. The prescaler and time do not advance on that edge; a tick due on that edge is dropped.
  - ST_CHECK: LOAD_READY = 0; prescaler and time frozen. Validation rules:
    - every nibble <= 9;
    - SS tens and MM tens <= 5;
    - HH <= 0x23.
  - ST_CHECK, valid load: on the next edge HH/MM/SS take the loaded values, prescaler = 0, LOAD_ACK pulses, FSM returns to ST_RUN.
  - ST_CHECK, invalid load: LOAD_ERR pulses instead; time and prescaler are unchanged; FSM returns to ST_RUN.
  - Load latency: 2 edges from accept to new HH/MM/SS; LOAD_READY is low for exactly one cycle.
- EN=0:
  - Prescaler and time hold; no SEC_PULSE or ROLLOVER.
  - The load path still operates normally.
- LOAD_VALID held high across ST_CHECK: a second load is accepted on the first ST_RUN cycle after the check.
- All outputs are registered; there are no combinational input-to-output paths.

Decomposition:
- Shared package clock_pkg:
  - state_t enum {ST_RUN, ST_CHECK};
  - BCD limit constants SEC_MAX=8'h59, MIN_MAX=8'h59, HOUR_MAX=8'h23;
  - function bcd_valid(value, max) returning the legality check.
- One sub-module, bcd_mod_counter:
  - parameter MAX (BCD);
  - ports CLK, RST, inc, load, load_val, value[7:0], carry;
  - instantiated three times (SS, MM, HH).

Test Plan (TICKS_PER_SEC=4):
1. Reset then EN=1 for 12 cycles -> SEC_PULSE high in the cycles after edges 4, 8, 12; SS = 03; MM = HH = 00.
2. Load 23:59:58 (valid), run 8 ticks' worth of cycles -> LOAD_ACK one cycle; SS 59; then HH/MM/SS = 00:00:00 with ROLLOVER and SEC_PULSE high in the same cycle.
3. Load HH=0x24, then SS=0x5A, then MM=0x60 -> LOAD_ERR pulse each time; time unchanged; LOAD_READY low exactly one cycle per attempt.
4. LOAD_VALID asserted on the edge a tick is due at 00:00:05 -> tick dropped; loaded value appears 2 edges later; next SEC_PULSE 4 edges after the load applies.
5. EN=0 for 20 cycles at 12:34:56 -> no pulses, time held; a load of 01:02:03 still completes with LOAD_ACK.
6. RST asserted during ST_CHECK with a valid pending load -> next cycle HH/MM/SS = 00, no LOAD_ACK, LOAD_READY = 1.
